// File: rtl/tour_pkg.sv
// Shared encodings for the knight's tour replay path: opcodes, headings,
// response bytes and sequencer states.
package tour_pkg;

   localparam logic [3:0] MOVE    = 4'h4;
   localparam logic [3:0] MOVE_FF = 4'h5;

   typedef enum logic [7:0] {
      N = 8'h00,
      W = 8'h3F,
      S = 8'h7F,
      E = 8'hBF
   } heading_8_t;

   localparam logic [7:0] POS_ACK = 8'hA5;
   localparam logic [7:0] ACK     = 8'h5A;

   typedef enum logic [2:0] {
      IDLE,
      VERT,
      WAIT_V,
      HORZ,
      WAIT_H
   } state_t;

endpackage

// File: rtl/knight_move_decode.sv
// Turns a one-hot knight move into its vertical and horizontal command legs.
// The lowest set bit wins; an empty move yields zero-square N/E legs.
module knight_move_decode
   import tour_pkg::*;
(
   input  logic [7:0]  move,
   output logic [15:0] vert_cmd,
   output logic [15:0] horz_cmd
);

   heading_8_t v_head, h_head;
   logic [3:0] v_sq, h_sq;

   always_comb begin
      v_head = N;
      v_sq   = 4'd0;
      h_head = E;
      h_sq   = 4'd0;
      priority casez (move)
         8'b???????1: begin v_head = N; v_sq = 4'd2; h_head = W; h_sq = 4'd1; end
         8'b??????10: begin v_head = N; v_sq = 4'd2; h_head = E; h_sq = 4'd1; end
         8'b?????100: begin v_head = N; v_sq = 4'd1; h_head = W; h_sq = 4'd2; end
         8'b????1000: begin v_head = S; v_sq = 4'd1; h_head = W; h_sq = 4'd2; end
         8'b???10000: begin v_head = S; v_sq = 4'd2; h_head = W; h_sq = 4'd1; end
         8'b??100000: begin v_head = S; v_sq = 4'd2; h_head = E; h_sq = 4'd1; end
         8'b?1000000: begin v_head = S; v_sq = 4'd1; h_head = E; h_sq = 4'd2; end
         8'b10000000: begin v_head = N; v_sq = 4'd1; h_head = E; h_sq = 4'd2; end
         default: ;
      endcase
   end

   assign vert_cmd = {MOVE, v_head, v_sq};
   assign horz_cmd = {MOVE_FF, h_head, h_sq};

endmodule

// File: rtl/tour_move_sequencer.sv
// Replays the solved tour into cmd_proc as vertical/horizontal leg pairs;
// passes UART commands straight through while idle.
module tour_move_sequencer #(
   parameter int NUM_MOVES = 24,
   parameter int IDX_W     = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_tour,
   input  logic [7:0]       move,
   output logic [IDX_W-1:0] mv_indx,
   input  logic [15:0]      cmd_UART,
   input  logic             cmd_rdy_UART,
   input  logic             clr_cmd_rdy,
   input  logic             send_resp,
   output logic [15:0]      cmd,
   output logic             cmd_rdy,
   output logic [7:0]       resp
);

   import tour_pkg::*;

   state_t           state, state_nxt;
   logic [IDX_W-1:0] idx, idx_nxt;
   logic [15:0]      vert_cmd, horz_cmd;
   logic             last;

   knight_move_decode u_decode (
      .move     (move),
      .vert_cmd (vert_cmd),
      .horz_cmd (horz_cmd)
   );

   assign last    = (idx == IDX_W'(NUM_MOVES - 1));
   assign mv_indx = idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   // move is read combinationally at mv_indx, so the legs stay stable
   // for as long as the index is held.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      cmd       = cmd_UART;
      cmd_rdy   = cmd_rdy_UART;
      resp      = POS_ACK;
      case (state)
         IDLE: begin
            if (start_tour) begin
               idx_nxt   = '0;
               state_nxt = VERT;
            end
         end
         VERT: begin
            cmd     = vert_cmd;
            cmd_rdy = 1'b1;
            resp    = ACK;
            if (clr_cmd_rdy) state_nxt = WAIT_V;
         end
         WAIT_V: begin
            cmd     = vert_cmd;
            cmd_rdy = 1'b0;
            resp    = ACK;
            if (send_resp) state_nxt = HORZ;
         end
         HORZ: begin
            cmd     = horz_cmd;
            cmd_rdy = 1'b1;
            resp    = ACK;
            if (clr_cmd_rdy) state_nxt = WAIT_H;
         end
         WAIT_H: begin
            cmd     = horz_cmd;
            cmd_rdy = 1'b0;
            resp    = last ? POS_ACK : ACK;
            if (send_resp) begin
               if (last) begin
                  idx_nxt   = '0;
                  state_nxt = IDLE;
               end else begin
                  idx_nxt   = idx + IDX_W'(1);
                  state_nxt = VERT;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
